// File: rtl/loadstore_unit.sv
// Purpose: memory-stage load/store sequencer; byte/half/word requests become word
//          accesses on a sync-read, active-low-write memory (sub-word stores use RMW).
// Latency: done at cycle 3 (load), 2 (word store), 4 (byte/half store), 1 (trapped misalign).
// Backpressure: req_ready only in IDLE; one request in flight, req_valid is ignored while busy.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake; accepted on valid && ready
//   req_store, req_size,          op (1=store), size (00 b, 01 h, 10/11 w),
//   req_unsigned, req_addr,       zero-extend for loads, byte address,
//   req_wdata                     store data taken from the low bytes
//   resp_done, resp_err,          one-cycle completion pulse, misalign flag,
//   resp_rdata                    extended load result (held until the next load)
//   mem_address, mem_dataIn,      word address, write word,
//   mem_we, mem_dataOut           active-low write enable, read word (one cycle after address)
//
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, a misaligned half/word request makes
// no memory access and completes next cycle with resp_err=1. When undefined, the offending
// low address bits are ignored and the access proceeds as aligned.

module loadstore_unit #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_store,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_done,
   output logic                  resp_err,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_dataIn,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_dataOut
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

   state_t                state;
   logic [ADDR_WIDTH+1:0] addr_q;
   logic [1:0]            size_q;
   logic                  store_q;
   logic                  unsigned_q;
   // Holds the raw store data until CAP, then the merged word for an RMW store.
   logic [DATA_WIDTH-1:0] wbuf_q;

   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [DATA_WIDTH-1:0] load_val;
   logic [DATA_WIDTH-1:0] merged;

   // Address bits above the attached memory are deliberately ignored.
   logic unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

   assign req_ready   = (state == IDLE);
   assign resp_done   = (state == RESP);
   assign mem_we      = (state != WR);
   assign mem_address = addr_q[ADDR_WIDTH+1:2];
   assign mem_dataIn  = wbuf_q;

`ifdef LSU_MISALIGN_TRAP_EN
   logic misalign;
   logic err_q;
   assign resp_err = err_q;

   always_comb begin
      case (req_size)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = req_addr[0];
         default: misalign = |req_addr[1:0];
      endcase
   end
`else
   assign resp_err = 1'b0;
`endif

   // Lane extraction for loads and lane merge for sub-word stores, both working on
   // the word returned by the memory in CAP. Little-endian lanes.
   always_comb begin
      case (addr_q[1:0])
         2'd0:    byte_sel = mem_dataOut[7:0];
         2'd1:    byte_sel = mem_dataOut[15:8];
         2'd2:    byte_sel = mem_dataOut[23:16];
         default: byte_sel = mem_dataOut[31:24];
      endcase
      half_sel = addr_q[1] ? mem_dataOut[31:16] : mem_dataOut[15:0];

      case (size_q)
         2'b00:   load_val = unsigned_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   load_val = unsigned_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_val = mem_dataOut;
      endcase

      merged = mem_dataOut;
      if (size_q == 2'b01) begin
         if (addr_q[1]) merged[31:16] = wbuf_q[15:0];
         else           merged[15:0]  = wbuf_q[15:0];
      end else begin
         case (addr_q[1:0])
            2'd0:    merged[7:0]   = wbuf_q[7:0];
            2'd1:    merged[15:8]  = wbuf_q[7:0];
            2'd2:    merged[23:16] = wbuf_q[7:0];
            default: merged[31:24] = wbuf_q[7:0];
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         addr_q     <= '0;
         size_q     <= 2'b00;
         store_q    <= 1'b0;
         unsigned_q <= 1'b0;
         wbuf_q     <= '0;
         resp_rdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         err_q      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q     <= req_addr[ADDR_WIDTH+1:0];
                  size_q     <= req_size;
                  store_q    <= req_store;
                  unsigned_q <= req_unsigned;
                  wbuf_q     <= req_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
                  err_q      <= misalign;
                  if (misalign)
                     state <= RESP;
                  else
`endif
                  if (req_store && req_size[1])
                     state <= WR;
                  else
                     state <= RD;
               end
            end
            RD:   state <= CAP;
            CAP: begin
               if (store_q) begin
                  wbuf_q <= merged;
                  state  <= WR;
               end else begin
                  resp_rdata <= load_val;
                  state      <= RESP;
               end
            end
            WR:   state <= RESP;
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
